// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges the never-stalled load path and the backpressured ALU path onto the
// single register-file write port. Optional stall counter enabled by defining WB_STALL_COUNT_EN.
module writeback_arbiter #(
   parameter int unsigned XLEN           = 32,
   parameter int unsigned ALU_FIFO_DEPTH = 2
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            alu_valid,
   output logic                            alu_ready,
   input  logic [4:0]                      alu_rd_index,
   input  logic [XLEN-1:0]                 alu_result,
   input  logic                            ld_valid,
   input  logic [4:0]                      ld_rd_index,
   input  logic [2:0]                      ld_funct3,
   input  logic [1:0]                      ld_addr_lo,
   input  logic [XLEN-1:0]                 ld_word,
   output logic [4:0]                      rd_index,
   output logic [XLEN-1:0]                 rd,
   output logic                            write_en,
   output logic [$clog2(ALU_FIFO_DEPTH):0] alu_fifo_count
`ifdef WB_STALL_COUNT_EN
   ,
   output logic [31:0]                     stall_cycles
`endif
);

   localparam int unsigned PtrW = $clog2(ALU_FIFO_DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   logic [4:0]      fifo_idx_q  [ALU_FIFO_DEPTH];
   logic [XLEN-1:0] fifo_data_q [ALU_FIFO_DEPTH];
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic [4:0]      rd_index_q, rd_index_d;
   logic [XLEN-1:0] rd_q, rd_d;
   logic            write_en_q, write_en_d;

   logic            fifo_empty, accept, push, pop, bypass, ld_legal;
   logic [7:0]      ld_byte;
   logic [15:0]     ld_half;
   logic [XLEN-1:0] ld_data;

   assign fifo_empty     = (count_q == '0);
   assign alu_ready      = (count_q != CntW'(ALU_FIFO_DEPTH));
   assign alu_fifo_count = count_q;
   assign rd_index       = rd_index_q;
   assign rd             = rd_q;
   assign write_en       = write_en_q;

   assign ld_byte = ld_word[{ld_addr_lo, 3'b000} +: 8];
   assign ld_half = ld_word[{ld_addr_lo[1], 4'b0000} +: 16];

   always_comb begin
      ld_data  = '0;
      ld_legal = 1'b1;
      case (ld_funct3)
         3'b000:  ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
         3'b001:  ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
         3'b010:  ld_data = ld_word;
         3'b100:  ld_data = {{(XLEN-8){1'b0}}, ld_byte};
         3'b101:  ld_data = {{(XLEN-16){1'b0}}, ld_half};
         default: ld_legal = 1'b0;
      endcase
   end

   always_comb begin
      // An illegal load still owns the port, so the FIFO must not pop under it.
      pop    = !ld_valid && !fifo_empty;
      bypass = !ld_valid && fifo_empty && alu_valid;
      accept = alu_valid && alu_ready;
      push   = accept && !bypass;

      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q + CntW'(push) - CntW'(pop);

      write_en_d = 1'b0;
      rd_index_d = rd_index_q;
      rd_d       = rd_q;
      if (ld_valid) begin
         if (ld_legal) begin
            rd_index_d = ld_rd_index;
            rd_d       = ld_data;
            write_en_d = (ld_rd_index != 5'd0);
         end
      end else if (pop) begin
         rd_index_d = fifo_idx_q[rd_ptr_q];
         rd_d       = fifo_data_q[rd_ptr_q];
         write_en_d = (fifo_idx_q[rd_ptr_q] != 5'd0);
      end else if (bypass) begin
         rd_index_d = alu_rd_index;
         rd_d       = alu_result;
         write_en_d = (alu_rd_index != 5'd0);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         rd_index_q <= '0;
         rd_q       <= '0;
         write_en_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         rd_index_q <= rd_index_d;
         rd_q       <= rd_d;
         write_en_q <= write_en_d;
      end
   end

   // Storage needs no reset: occupancy is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_idx_q[wr_ptr_q]  <= alu_rd_index;
         fifo_data_q[wr_ptr_q] <= alu_result;
      end
   end

`ifdef WB_STALL_COUNT_EN
   logic [31:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if (alu_valid && !alu_ready && (stall_q != 32'hFFFF_FFFF)) stall_d = stall_q + 32'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) stall_q <= '0;
      else       stall_q <= stall_d;
   end

   assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed self-checking bench for writeback_arbiter (default depth 2, 32-bit datapath).
module tb_writeback_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        alu_valid, alu_ready;
   logic [4:0]  alu_rd_index;
   logic [31:0] alu_result;
   logic        ld_valid;
   logic [4:0]  ld_rd_index;
   logic [2:0]  ld_funct3;
   logic [1:0]  ld_addr_lo;
   logic [31:0] ld_word;
   logic [4:0]  rd_index;
   logic [31:0] rd;
   logic        write_en;
   logic [1:0]  alu_fifo_count;
`ifdef WB_STALL_COUNT_EN
   logic [31:0] stall_cycles;
`endif

   int n_checks = 0;
   int n_errors = 0;

   writeback_arbiter dut (
      .clk            (clk),
      .reset          (reset),
      .alu_valid      (alu_valid),
      .alu_ready      (alu_ready),
      .alu_rd_index   (alu_rd_index),
      .alu_result     (alu_result),
      .ld_valid       (ld_valid),
      .ld_rd_index    (ld_rd_index),
      .ld_funct3      (ld_funct3),
      .ld_addr_lo     (ld_addr_lo),
      .ld_word        (ld_word),
      .rd_index       (rd_index),
      .rd             (rd),
      .write_en       (write_en),
      .alu_fifo_count (alu_fifo_count)
`ifdef WB_STALL_COUNT_EN
      ,
      .stall_cycles   (stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_chk(input string tag, input logic [2:0] f3, input logic [1:0] lo,
                           input logic [31:0] word, input logic [4:0] idx,
                           input logic exp_we, input logic [31:0] exp_rd);
      ld_valid    = 1'b1;
      ld_funct3   = f3;
      ld_addr_lo  = lo;
      ld_word     = word;
      ld_rd_index = idx;
      step();
      ld_valid = 1'b0;
      check_eq({tag, "_we"}, 32'(write_en), 32'(exp_we));
      if (exp_we) begin
         check_eq({tag, "_rd"}, rd, exp_rd);
         check_eq({tag, "_idx"}, 32'(rd_index), 32'(idx));
      end
   endtask

   initial begin
      reset        = 1'b1;
      alu_valid    = 1'b0;
      alu_rd_index = '0;
      alu_result   = '0;
      ld_valid     = 1'b0;
      ld_rd_index  = '0;
      ld_funct3    = '0;
      ld_addr_lo   = '0;
      ld_word      = '0;
      step();
      step();
      check_eq("rst_we", 32'(write_en), 32'd0);
      check_eq("rst_rd", rd, 32'd0);
      check_eq("rst_idx", 32'(rd_index), 32'd0);
      check_eq("rst_cnt", 32'(alu_fifo_count), 32'd0);
      check_eq("rst_ready", 32'(alu_ready), 32'd1);
      reset = 1'b0;
      step();

      // ALU bypass with empty FIFO
      alu_valid    = 1'b1;
      alu_rd_index = 5'd5;
      alu_result   = 32'h1234_5678;
      step();
      alu_valid = 1'b0;
      check_eq("byp_we", 32'(write_en), 32'd1);
      check_eq("byp_idx", 32'(rd_index), 32'd5);
      check_eq("byp_rd", rd, 32'h1234_5678);
      check_eq("byp_cnt", 32'(alu_fifo_count), 32'd0);
      step();
      check_eq("byp_once", 32'(write_en), 32'd0);
      check_eq("hold_rd", rd, 32'h1234_5678);

      // Load alignment
      load_chk("lb",   3'b000, 2'd3, 32'h80FF_7F01, 5'd7, 1'b1, 32'hFFFF_FF80);
      load_chk("lbu",  3'b100, 2'd3, 32'h80FF_7F01, 5'd7, 1'b1, 32'h0000_0080);
      load_chk("lh",   3'b001, 2'd2, 32'h80FF_7F01, 5'd7, 1'b1, 32'hFFFF_80FF);
      load_chk("lhu1", 3'b101, 2'd1, 32'h80FF_7F01, 5'd8, 1'b1, 32'h0000_7F01);
      load_chk("lb1",  3'b000, 2'd1, 32'h80FF_7F01, 5'd9, 1'b1, 32'h0000_007F);
      load_chk("lw",   3'b010, 2'd3, 32'h80FF_7F01, 5'd4, 1'b1, 32'h80FF_7F01);
      load_chk("ill3", 3'b011, 2'd0, 32'h80FF_7F01, 5'd4, 1'b0, 32'h0);
      load_chk("ill6", 3'b110, 2'd0, 32'h80FF_7F01, 5'd4, 1'b0, 32'h0);

      // Loads occupy the port while ALU results A, B, C arrive
      ld_valid = 1'b1; ld_funct3 = 3'b010; ld_rd_index = 5'd9; ld_word = 32'hDEAD_0001;
      alu_valid = 1'b1; alu_rd_index = 5'd10; alu_result = 32'hAAAA_0001;
      check_eq("s_ready0", 32'(alu_ready), 32'd1);
      step();
      check_eq("s_ld_we", 32'(write_en), 32'd1);
      check_eq("s_ld_idx", 32'(rd_index), 32'd9);
      check_eq("s_cnt1", 32'(alu_fifo_count), 32'd1);
      alu_rd_index = 5'd11; alu_result = 32'hBBBB_0002;
      step();
      check_eq("s_cnt2", 32'(alu_fifo_count), 32'd2);
      check_eq("s_ready_full", 32'(alu_ready), 32'd0);
      alu_rd_index = 5'd12; alu_result = 32'hCCCC_0003;
      step();
      check_eq("s_hold_cnt", 32'(alu_fifo_count), 32'd2);
      step();
      ld_valid = 1'b0;
      check_eq("s_hold_cnt2", 32'(alu_fifo_count), 32'd2);
      check_eq("s_ld_rd", rd, 32'hDEAD_0001);
      step();
      check_eq("s_a_rd", rd, 32'hAAAA_0001);
      check_eq("s_a_idx", 32'(rd_index), 32'd10);
      check_eq("s_a_cnt", 32'(alu_fifo_count), 32'd1);
      check_eq("s_a_ready", 32'(alu_ready), 32'd1);
      step();
      alu_valid = 1'b0;
      check_eq("s_b_rd", rd, 32'hBBBB_0002);
      check_eq("s_b_we", 32'(write_en), 32'd1);
      check_eq("s_b_cnt", 32'(alu_fifo_count), 32'd1);
      step();
      check_eq("s_c_rd", rd, 32'hCCCC_0003);
      check_eq("s_c_idx", 32'(rd_index), 32'd12);
      check_eq("s_c_cnt", 32'(alu_fifo_count), 32'd0);
      step();
      check_eq("s_idle", 32'(write_en), 32'd0);

      // Writes to x0 are consumed without a strobe
      alu_valid = 1'b1; alu_rd_index = 5'd0; alu_result = 32'h5555_5555;
      step();
      alu_valid = 1'b0;
      check_eq("x0_byp_we", 32'(write_en), 32'd0);
      ld_valid = 1'b1; ld_rd_index = 5'd0; ld_funct3 = 3'b010;
      alu_valid = 1'b1; alu_rd_index = 5'd0;
      step();
      ld_valid = 1'b0; alu_valid = 1'b0;
      check_eq("x0_ld_we", 32'(write_en), 32'd0);
      check_eq("x0_cnt1", 32'(alu_fifo_count), 32'd1);
      step();
      check_eq("x0_pop_we", 32'(write_en), 32'd0);
      check_eq("x0_cnt0", 32'(alu_fifo_count), 32'd0);

      // Asynchronous reset with two buffered results
      ld_valid = 1'b1; ld_rd_index = 5'd3; ld_word = 32'h0000_0033;
      alu_valid = 1'b1; alu_rd_index = 5'd20; alu_result = 32'h0000_0020;
      step();
      alu_rd_index = 5'd21; alu_result = 32'h0000_0021;
      step();
      check_eq("r_cnt2", 32'(alu_fifo_count), 32'd2);
      check_eq("r_pre_we", 32'(write_en), 32'd1);
      ld_valid = 1'b0; alu_valid = 1'b0;
      reset = 1'b1;
      #1;
      check_eq("r_async_we", 32'(write_en), 32'd0);
      check_eq("r_async_rd", rd, 32'd0);
      check_eq("r_async_idx", 32'(rd_index), 32'd0);
      check_eq("r_async_cnt", 32'(alu_fifo_count), 32'd0);
      step();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check_eq("r_no_stale", 32'(write_en), 32'd0);
      end
      check_eq("r_cnt_after", 32'(alu_fifo_count), 32'd0);

`ifdef WB_STALL_COUNT_EN
      check_eq("st_reset", stall_cycles, 32'd0);
      ld_valid = 1'b1; ld_rd_index = 5'd1; ld_funct3 = 3'b010;
      alu_valid = 1'b1; alu_rd_index = 5'd2;
      step();
      step();
      check_eq("st_full", 32'(alu_fifo_count), 32'd2);
      for (int i = 0; i < 5; i++) step();
      alu_valid = 1'b0;
      check_eq("st_five", stall_cycles, 32'd5);
      ld_valid = 1'b0;
      step();
      step();
      step();
      check_eq("st_drained", 32'(alu_fifo_count), 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
